// File: rtl/stepper_move_queue.sv
// stepper_move_queue
// Move-command queue in front of the per-axis step generator. Commands
// (steps, period, dir) are buffered in a FIFO and issued one at a time.
// When a move reverses direction, the dir line is changed first and held
// for DIR_SETUP cycles before the generator is started. The next move is
// issued only after the generator reports that the current one is finished.
module stepper_move_queue #(
    parameter int DEPTH     = 8,   // FIFO entries, power of two, 2..64
    parameter int DIR_SETUP = 4    // dir-to-start setup cycles, >= 1
) (
    input  logic                     clk,
    input  logic                     reset,       // async, active low
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [30:0]              cmd_steps,
    input  logic [31:0]              cmd_period,
    input  logic                     cmd_dir,
    input  logic                     flush,
    output logic [31:0]              gen_period,
    output logic [30:0]              gen_count,
    output logic                     gen_start,
    output logic                     gen_abort,
    input  logic                     gen_finish,
    output logic                     dir,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              moves_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] SETUP_INIT = CW'(DIR_SETUP - 1);

    // FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DSETUP = 2'd1;
    localparam logic [1:0] S_START  = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    // FIFO storage: {dir, period, steps}
    logic [63:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_level;

    // Control state
    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_first;      // first RUN cycle: masks a stale finish
    logic           r_dir;
    logic           r_abort;
    logic [31:0]    r_period;
    logic [30:0]    r_count;
    logic [15:0]    r_moves;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic [63:0]    w_head;
    logic [30:0]    w_h_steps;
    logic [31:0]    w_h_period;
    logic           w_h_dir;

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign cmd_ready  = !w_full && !flush;
    assign w_push     = cmd_valid && cmd_ready;
    // Only IDLE consumes entries; flush overrides any pop in its cycle.
    assign w_pop      = (r_state == S_IDLE) && !w_empty && !flush;

    assign w_head     = r_mem[r_rptr];
    assign w_h_steps  = w_head[30:0];
    assign w_h_period = w_head[62:31];
    assign w_h_dir    = w_head[63];

    // FIFO storage write; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {cmd_dir, cmd_period, cmd_steps};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Move sequencer: pop, optional dir setup, start pulse, wait for finish
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_first  <= 1'b0;
            r_dir    <= 1'b0;
            r_abort  <= 1'b0;
            r_period <= '0;
            r_count  <= '0;
            r_moves  <= '0;
        end else if (flush) begin
            // Abort only when a move is actually in progress; dir is kept.
            r_abort  <= (r_state != S_IDLE);
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_first  <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Zero-step entries are dropped here, one per cycle.
                    if (w_pop && (w_h_steps != '0)) begin
                        r_period <= w_h_period;
                        r_count  <= w_h_steps;
                        if (w_h_dir != r_dir) begin
                            r_dir   <= w_h_dir;
                            r_cnt   <= SETUP_INIT;
                            r_state <= S_DSETUP;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end
                S_DSETUP: begin
                    if (r_cnt == '0)
                        r_state <= S_START;
                    else
                        r_cnt <= r_cnt - CNT_ONE;
                end
                S_START: begin
                    r_state <= S_RUN;
                    r_first <= 1'b1;
                end
                S_RUN: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                    end else if (gen_finish) begin
                        r_moves <= r_moves + 16'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gen_start  = (r_state == S_START);
    assign gen_abort  = r_abort;
    assign gen_period = r_period;
    assign gen_count  = r_count;
    assign dir        = r_dir;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign level      = r_level;
    assign moves_done = r_moves;

endmodule

// File: tb/tb_stepper_move_queue.sv
// tb_stepper_move_queue
// Directed stimulus; expected generator loads are queued on each push and a
// separate monitor checks them whenever gen_start pulses.
module tb_stepper_move_queue;

    localparam int DEPTH     = 8;
    localparam int DIR_SETUP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [30:0] cmd_steps = '0;
    logic [31:0] cmd_period = '0;
    logic        cmd_dir = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] gen_period;
    logic [30:0] gen_count;
    logic        gen_start;
    logic        gen_abort;
    logic        gen_finish = 1'b0;
    logic        dir;
    logic        busy;
    logic [3:0]  level;
    logic [15:0] moves_done;

    stepper_move_queue #(.DEPTH(DEPTH), .DIR_SETUP(DIR_SETUP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .cmd_dir(cmd_dir),
        .flush(flush),
        .gen_period(gen_period), .gen_count(gen_count),
        .gen_start(gen_start), .gen_abort(gen_abort), .gen_finish(gen_finish),
        .dir(dir), .busy(busy), .level(level), .moves_done(moves_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [30:0] steps;
        logic [31:0] period;
        logic        dir;
    } mv_t;

    mv_t sb[$];
    mv_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every start pulse must match the oldest outstanding move.
    always @(negedge clk) begin
        if (reset && gen_start) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_start: got gen_count=%0d expected no start", gen_count);
            end else begin
                mon_e = sb.pop_front();
                check("start_count",  {33'd0, gen_count}, {33'd0, mon_e.steps});
                check("start_period", {32'd0, gen_period}, {32'd0, mon_e.period});
                check("start_dir",    {63'd0, dir}, {63'd0, mon_e.dir});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [30:0] s, input logic [31:0] p, input logic d);
        cmd_valid  = 1'b1;
        cmd_steps  = s;
        cmd_period = p;
        cmd_dir    = d;
    endtask

    task automatic push(input logic [30:0] s, input logic [31:0] p, input logic d, input bit exp);
        mv_t m;
        drive(s, p, d);
        #1;
        check("push_ready", {63'd0, cmd_ready}, 64'd1);
        if (exp) begin
            m.steps = s; m.period = p; m.dir = d;
            sb.push_back(m);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns the cycle in which gen_start is seen (current cycle included).
    task automatic wait_start(output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            if (gen_start) at = cyc;
            else tick();
        end
        if (at < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL start_timeout: got no gen_start expected one within 40 cycles");
        end
    endtask

    // From a START cycle: skip the masked first RUN cycle, then finish.
    task automatic run_finish();
        tick();
        tick();
        gen_finish = 1'b1;
        tick();
        gen_finish = 1'b0;
    endtask

    task automatic finish_move();
        int at;
        wait_start(at);
        run_finish();
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_level"},  {60'd0, level}, 64'd0);
        check({tag, "_ready"},  {63'd0, cmd_ready}, 64'd1);
        check({tag, "_start"},  {63'd0, gen_start}, 64'd0);
        check({tag, "_abort"},  {63'd0, gen_abort}, 64'd0);
        check({tag, "_dir"},    {63'd0, dir}, 64'd0);
        check({tag, "_busy"},   {63'd0, busy}, 64'd0);
        check({tag, "_moves"},  {48'd0, moves_done}, 64'd0);
        check({tag, "_period"}, {32'd0, gen_period}, 64'd0);
        check({tag, "_count"},  {33'd0, gen_count}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end

    initial begin
        int d, at, at2, rise, f, k, seen;

        // Reset held for 3 cycles, then released
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset = 1'b1;
        tick();
        chk_reset_vals("rel");

        // Single move, same direction
        d = cyc;
        push(31'd10, 32'd100, 1'b0, 1'b1);
        check("t2_level_after_push", {60'd0, level}, 64'd1);
        check("t2_busy", {63'd0, busy}, 64'd1);
        wait_start(at);
        check("t2_push_to_start", 64'(at - d), 64'd2);
        tick();
        gen_finish = 1'b1;           // first RUN cycle: must be ignored
        tick();
        gen_finish = 1'b0;
        check("t2_stale_finish_moves", {48'd0, moves_done}, 64'd0);
        check("t2_stale_finish_busy", {63'd0, busy}, 64'd1);
        repeat (3) tick();
        gen_finish = 1'b1;
        tick();
        gen_finish = 1'b0;
        check("t2_moves_done", {48'd0, moves_done}, 64'd1);
        check("t2_busy_low", {63'd0, busy}, 64'd0);

        // Direction change with setup delay
        d = cyc;
        push(31'd5, 32'd50, 1'b1, 1'b1);
        check("t3_dir_before_pop", {63'd0, dir}, 64'd0);
        tick();
        check("t3_dir_at_pop", {63'd0, dir}, 64'd1);
        rise = cyc;
        wait_start(at);
        check("t3_dir_setup", 64'(at - rise), 64'(DIR_SETUP));
        check("t3_push_to_start", 64'(at - d), 64'(2 + DIR_SETUP));
        push(31'd3, 32'd30, 1'b1, 1'b1);
        tick();
        check("t3_level_queued", {60'd0, level}, 64'd1);
        f = cyc;
        gen_finish = 1'b1;
        tick();
        gen_finish = 1'b0;
        wait_start(at2);
        check("t3_finish_to_start", 64'(at2 - f), 64'd2);
        check("t3_moves_done", {48'd0, moves_done}, 64'd2);

        // Fill the FIFO while the generator is stalled in RUN
        for (int i = 0; i < DEPTH; i++)
            push(31'(i + 1), 32'(1000 + i), 1'b1, 1'b1);
        check("t4_level_full", {60'd0, level}, 64'd8);
        check("t4_ready_full", {63'd0, cmd_ready}, 64'd0);
        drive(31'd99, 32'd9, 1'b1);
        #1;
        check("t4_ready_9th", {63'd0, cmd_ready}, 64'd0);
        tick();
        cmd_valid = 1'b0;
        check("t4_level_9th", {60'd0, level}, 64'd8);
        gen_finish = 1'b1;
        tick();
        gen_finish = 1'b0;
        check("t4_level_idle", {60'd0, level}, 64'd8);
        tick();
        check("t4_level_after_pop", {60'd0, level}, 64'd7);
        check("t4_ready_after_pop", {63'd0, cmd_ready}, 64'd1);
        check("t4_start_after_pop", {63'd0, gen_start}, 64'd1);
        tick();
        tick();
        gen_finish = 1'b1;
        tick();
        gen_finish = 1'b0;
        push(31'd20, 32'd2000, 1'b1, 1'b1);   // pushed in the pop cycle
        check("t4_push_pop_level", {60'd0, level}, 64'd7);
        for (int i = 0; i < 8; i++)
            finish_move();
        check("t4_moves_done", {48'd0, moves_done}, 64'd12);
        check("t4_drained_level", {60'd0, level}, 64'd0);
        check("t4_drained_busy", {63'd0, busy}, 64'd0);

        // Zero-step entries are discarded without touching dir
        k = cyc;
        push(31'd0, 32'd11, 1'b0, 1'b0);
        push(31'd0, 32'd12, 1'b0, 1'b0);
        push(31'd7, 32'd70, 1'b1, 1'b1);
        wait_start(at);
        check("t5_skip_latency", 64'(at - k), 64'd4);
        check("t5_dir_kept", {63'd0, dir}, 64'd1);
        run_finish();
        check("t5_moves_done", {48'd0, moves_done}, 64'd13);

        // Flush while idle: no abort
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_idle_flush_abort", {63'd0, gen_abort}, 64'd0);
        check("t6_idle_flush_level", {60'd0, level}, 64'd0);
        tick();

        // Flush in RUN with a command and a finish in the same cycle
        push(31'd4, 32'd40, 1'b1, 1'b1);
        push(31'd5, 32'd50, 1'b1, 1'b0);
        wait_start(at);
        push(31'd6, 32'd60, 1'b1, 1'b0);
        tick();
        check("t7_level_before", {60'd0, level}, 64'd2);
        flush = 1'b1;
        gen_finish = 1'b1;
        drive(31'd9, 32'd90, 1'b0);
        #1;
        check("t7_ready_flush", {63'd0, cmd_ready}, 64'd0);
        tick();
        flush = 1'b0;
        gen_finish = 1'b0;
        cmd_valid = 1'b0;
        check("t7_abort", {63'd0, gen_abort}, 64'd1);
        check("t7_level", {60'd0, level}, 64'd0);
        check("t7_busy", {63'd0, busy}, 64'd0);
        check("t7_dir_kept", {63'd0, dir}, 64'd1);
        check("t7_moves_done", {48'd0, moves_done}, 64'd13);
        tick();
        check("t7_abort_one_cycle", {63'd0, gen_abort}, 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gen_start) seen++;
        end
        check("t7_no_start", 64'(seen), 64'd0);
        check("t7_level_end", {60'd0, level}, 64'd0);

        // Reset in the middle of a move
        push(31'd8, 32'd80, 1'b0, 1'b1);
        wait_start(at);
        tick();
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        reset = 1'b1;
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_move_queue.md
Name: stepper_move_queue

Overview:
- Command stage directly upstream of the per-axis step generator (clk_gen inside stepper_control).
- Buffers move commands (step count, step period, direction) in a FIFO and hands them one at a time to the generator.
- Drives the direction line with a programmable setup delay before each move that changes direction, then waits for the generator's finish before issuing the next move.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DIR_SETUP, 4, clk cycles the dir output is held stable before gen_start after a direction change; minimum 1.

Ports:
- clk  in  1  system clock (fpga_clk domain)
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; transfer when cmd_valid && cmd_ready on rising clk
- cmd_steps  in  31  number of steps in the move
- cmd_period  in  32  step period (clk_gen reduction)
- cmd_dir  in  1  direction of the move
- flush  in  1  synchronous abort: empty the FIFO and cancel the active move
- gen_period  out  32  reduction to the step generator, held for the whole move
- gen_count  out  31  step count to the step generator, held for the whole move
- gen_start  out  1  one-cycle pulse that (re)starts the generator
- gen_abort  out  1  one-cycle pulse that stops the generator on flush
- gen_finish  in  1  generator completion, level or pulse
- dir  out  1  direction line to the driver
- busy  out  1  high when state != IDLE or FIFO not empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- moves_done  out  16  completed-move counter, wraps at 65535 -> 0

Behaviour:
- Reset values (reset low, asynchronous):
  - FIFO empty, level=0, cmd_ready=1.
  - gen_period=0, gen_count=0, gen_start=0, gen_abort=0.
  - dir=0, busy=0, moves_done=0, state=IDLE.
- FIFO and handshake:
  - cmd_ready = !full && !flush (combinational).
  - Push and pop in the same cycle are allowed; level stays unchanged.
  - A push while full is impossible because ready is low.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DSETUP, START, RUN.
- IDLE:
  - If FIFO is not empty, pop the head.
  - If the head has steps==0, discard it: stay in IDLE, no gen_start, moves_done unchanged. This consumes one cycle per discarded entry.
  - Otherwise load gen_period and gen_count from the head.
  - If cmd_dir != dir: set dir=cmd_dir in the same cycle, load the setup counter with DIR_SETUP-1, go to DSETUP.
  - Else go to START.
- DSETUP: decrement the counter each cycle; go to START when it is 0. Result: dir is stable for exactly DIR_SETUP cycles before the gen_start cycle.
- START: gen_start=1 for this cycle only; go to RUN.
- RUN:
  - gen_finish is ignored in the first RUN cycle, which masks a stale finish from the previous move.
  - From the second RUN cycle on, gen_finish=1 -> moves_done+1, go to IDLE.
- Latency:
  - Accepted command into an idle, empty queue, same dir: gen_start 2 cycles after the push edge (it is visible in the FIFO the next cycle; IDLE pops; START).
  - Finish to next gen_start with the same dir: gen_finish seen in cycle N -> IDLE in N+1 -> gen_start in N+2.
  - With a direction change: add DIR_SETUP cycles.
- gen_period and gen_count change only on a non-zero pop in IDLE. They are held through DSETUP, START and RUN.
- dir changes only in IDLE on a pop with a differing direction. It never changes in DSETUP, START or RUN.
- flush (highest priority; takes effect at the clock edge where it is high):
  - FIFO cleared, level=0, state=IDLE.
  - Setup counter cleared; any pending gen_start is suppressed.
  - gen_abort=1 for one cycle if state was DSETUP, START or RUN; no abort from IDLE.
  - cmd_valid in the flush cycle is dropped.
  - moves_done is not incremented for the aborted move; dir keeps its value.
  - gen_finish arriving in the flush cycle is ignored.
- Reset mid-move: all state returns to reset values immediately; there is no gen_abort pulse (the generator is reset by the same line).
- busy falls in the cycle after the final RUN->IDLE transition with the FIFO empty.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> all outputs at reset values, cmd_ready=1, level=0.
- Single move: push steps=10, period=100, dir=0 -> gen_start pulses once 2 cycles later with gen_count=10, gen_period=100, dir unchanged; drive gen_finish 5 cycles later -> moves_done=1, busy=0 the next cycle.
- Direction change: after the move above, push steps=5, dir=1 with DIR_SETUP=4 -> dir rises in the pop cycle and gen_start follows exactly 4 cycles later. Then push steps=3, dir=1 and finish the previous move -> next gen_start 2 cycles after gen_finish.
- Full/backpressure: push 8 moves with the generator stalled in RUN -> level=8, cmd_ready=0 and a 9th push is not taken. Pulse gen_finish -> level=7, cmd_ready=1 after the pop; a push and a pop in the same cycle leave level unchanged.
- Zero-step skip: queue {steps=0, steps=0, steps=7} -> no gen_start for the zeros, a single gen_start with gen_count=7, moves_done increments by 1 only.
- Flush mid-move: 3 moves queued, flush asserted in RUN together with cmd_valid -> one-cycle gen_abort, level=0, state IDLE, no further gen_start, moves_done unchanged, flush-cycle command dropped.
